button_seq_capture: RTL
=======================

// Module: button_seq_capture
// PURPOSE
//  Parametrised button-sequence recorder for the memory-game datapath. Conditions N_BTN raw
//  buttons (sync, optional debounce, rising-edge detect), rejects multi-presses, and stores
//  one button index per accepted press into a MAX_LEN-deep buffer until the level's target
//  length is reached. Feeds the sequence comparator and the level/score FSM.
// PARAMETERS
//  N_BTN      8   number of buttons
//  IDX_W      3   index width, $clog2(N_BTN)
//  MAX_LEN    16  buffer depth (entries)
//  LEN_W      5   count width, $clog2(MAX_LEN+1)
//  DB_CYCLES  16  debounce stability window in clk cycles (used only with debounce on)
// PORTS
//  clk         in   1              system clock, all state on posedge
//  rst         in   1              asynchronous reset, active-high
//  start       in   1              1-cycle pulse: clear buffer, latch level, begin capture
//  level       in   2              difficulty; sampled only on start
//  btn         in   N_BTN          raw button levels, asynchronous to clk
//  key_valid   out  1              1-cycle pulse per accepted press
//  key_idx     out  IDX_W          index of accepted press (valid with key_valid)
//  seq_flat    out  MAX_LEN*IDX_W  entry k at [k*IDX_W +: IDX_W]; unwritten entries = 0
//  count       out  LEN_W          number of entries stored
//  target_len  out  LEN_W          min(4*level+4, MAX_LEN), latched on start
//  busy        out  1              high in CAPTURE
//  end_signal  out  1              high in DONE (level, held until next start)
//  error_code  out  4              sticky flags, cleared on start
// BEHAVIOUR
//  - Reset (async, active-high): state IDLE; every output 0; sync/debounce/edge regs 0.
//  - FSM: IDLE --start--> CAPTURE --count==target_len--> DONE --start--> CAPTURE.
//    start in any state: clear seq_flat/count/error_code, latch target_len, enter CAPTURE.
//  - Condition: 2-flop sync per button -> debounced level -> rise = lvl & ~lvl_q.
//  - Accept in CAPTURE when exactly one rise this cycle and no other button level high:
//    write entry[count]<=idx, count<=count+1, key_valid=1 same cycle. Latency: raw edge to
//    key_valid = 3 clk (no debounce). On the write that makes count==target_len, move to
//    DONE next cycle; end_signal rises with the state change.
//  - Multi-press (>=2 rises, or rise while another held): nothing stored, error_code[0]<=1.
//  - Press in IDLE or DONE: ignored, error_code[1]<=1 (no overflow beyond target_len).
//  - start while CAPTURE with count>0: restart as above, then error_code[2]<=1 (abort).
//  - start and a rise in the same cycle: start wins, press dropped, no error flag.
//  - count never exceeds target_len; writes index by count, no wrap-around.
//  - error_code[3] reserved, always 0. Held button produces one press only.
// CONFIGURATION
//  BTN_DEBOUNCE_EN defined: per-button counter; debounced level follows synced level only
//    after DB_CYCLES consecutive equal samples; latency becomes 3+DB_CYCLES clk.
//  Not defined: debounced level = synced level; DB_CYCLES unused; no counters built.
// STRUCTURE
//  Package button_seq_pkg: state enum (IDLE/CAPTURE/DONE), ERR_MULTI/ERR_IGNORED/ERR_ABORT
//    bit positions, function target_len_f(level, MAX_LEN).
//  Sub-module btn_conditioner (sync + optional debounce + edge), one per button via
//    generate; top holds one-hot check, encoder, buffer, counters, FSM.
// TESTING
//  1 rst=1 mid-capture (count=5) -> all outputs 0 immediately, state IDLE after release.
//  2 level=1, start, press btn idx 2,0,7,... x8 -> key_valid x8, seq_flat[2:0]=2,
//    [5:3]=0, [8:6]=7, count=8, end_signal=1 after 8th; 9th press -> error_code=4'b0010.
//  3 level=3 (target 16): 16 presses fill buffer, entry 15 at [47:45]; 17th ignored.
//  4 btn[1],btn[4] rise same cycle -> no key_valid, count unchanged, error_code[0]=1;
//    btn[4] rise while btn[1] held -> same result.
//  5 start same cycle as btn[3] rise -> count=0, no error; start at count=3 -> count=0,
//    error_code=4'b0100.
//  6 BTN_DEBOUNCE_EN, DB_CYCLES=16: 5-cycle glitch -> no key_valid; 20-cycle press ->
//    key_valid exactly 19 clk after raw edge.

Source files
------------

// File: rtl/button_seq_pkg.sv
// Shared types and helpers for the button-sequence capture block.
package button_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Bit positions inside error_code
  localparam int unsigned ERR_MULTI   = 0;
  localparam int unsigned ERR_IGNORED = 1;
  localparam int unsigned ERR_ABORT   = 2;

  // Sequence length for a difficulty level: 4*level+4, capped at the buffer depth
  function automatic int unsigned target_len_f(input logic [1:0] level,
                                               input int unsigned max_len);
    int unsigned t;
    t = 4 * {30'd0, level} + 4;
    return (t < max_len) ? t : max_len;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Single-button conditioner: 2-flop synchroniser, optional debounce, rising-edge detect.
// Debounce is built only when BTN_DEBOUNCE_EN is defined.
module btn_conditioner
`ifdef BTN_DEBOUNCE_EN
  #(parameter int unsigned DB_CYCLES = 16)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic lvl_q;

  // Bring the asynchronous button level into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic [CNT_W-1:0] db_cnt;
  logic             db_lvl;

  // Follow the synced level only after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (sync2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_W'(DB_CYCLES - 1)) begin
      db_lvl <= sync2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign lvl = db_lvl;
`else
  assign lvl = sync2;
`endif

  // Delayed level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_q <= 1'b0;
    else     lvl_q <= lvl;
  end

  assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/button_seq_capture.sv
// Button-sequence recorder: conditions N_BTN buttons, rejects multi-presses and stores
// one index per accepted press until the level's target length is reached.
// Optional debounce on the button path: define BTN_DEBOUNCE_EN.
module button_seq_capture #(
  parameter int unsigned N_BTN     = 8,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned LEN_W     = 5,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               level,
  input  logic [N_BTN-1:0]         btn,
  output logic                     key_valid,
  output logic [IDX_W-1:0]         key_idx,
  output logic [MAX_LEN*IDX_W-1:0] seq_flat,
  output logic [LEN_W-1:0]         count,
  output logic [LEN_W-1:0]         target_len,
  output logic                     busy,
  output logic                     end_signal,
  output logic [3:0]               error_code
);

  import button_seq_pkg::*;

  if (IDX_W != $clog2(N_BTN) || LEN_W != $clog2(MAX_LEN + 1) || DB_CYCLES < 1) begin : g_param_check
    $error("button_seq_capture: inconsistent parameters");
  end

  logic [N_BTN-1:0] lvl;
  logic [N_BTN-1:0] rise;
  logic [IDX_W-1:0] rise_idx;
  logic             any_rise;
  logic             clean_press;
  logic             accept;
  logic [2:0]       err_flags;
  logic [IDX_W-1:0] entries [MAX_LEN];
  state_t           state;
  state_t           state_next;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
`ifdef BTN_DEBOUNCE_EN
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond (
`else
    btn_conditioner u_cond (
`endif
      .clk  (clk),
      .rst  (rst),
      .raw  (btn[i]),
      .lvl  (lvl[i]),
      .rise (rise[i])
    );
  end

  // Encode the rising button; only meaningful when exactly one bit is set
  always_comb begin
    rise_idx = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (rise[i]) rise_idx = IDX_W'(i);
    end
  end

  assign any_rise    = |rise;
  assign clean_press = $onehot(rise) && ((lvl & ~rise) == '0);
  assign accept      = (state == CAPTURE) && !start && clean_press && (count < target_len);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: start always (re)enters CAPTURE; the completing write moves to DONE
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = CAPTURE;
    end else if (state == CAPTURE && accept && (count + LEN_W'(1)) == target_len) begin
      state_next = DONE;
    end
  end

  assign busy       = (state == CAPTURE);
  assign end_signal = (state == DONE);

  // Buffer, counters, key strobe and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < MAX_LEN; k++) entries[k] <= '0;
      count      <= '0;
      target_len <= '0;
      key_valid  <= 1'b0;
      key_idx    <= '0;
      err_flags  <= '0;
    end else begin
      key_valid <= 1'b0;
      if (start) begin
        // Start wins over any press in the same cycle; abort is flagged after the clear
        for (int unsigned k = 0; k < MAX_LEN; k++) entries[k] <= '0;
        count      <= '0;
        target_len <= LEN_W'(target_len_f(level, MAX_LEN));
        err_flags  <= '0;
        if (state == CAPTURE && count != '0) err_flags[ERR_ABORT] <= 1'b1;
      end else if (any_rise) begin
        if (accept) begin
          for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if (LEN_W'(k) == count) entries[k] <= rise_idx;
          end
          count     <= count + 1'b1;
          key_valid <= 1'b1;
          key_idx   <= rise_idx;
        end else if (state == CAPTURE && !clean_press) begin
          err_flags[ERR_MULTI] <= 1'b1;
        end else begin
          err_flags[ERR_IGNORED] <= 1'b1;
        end
      end
    end
  end

  assign error_code = {1'b0, err_flags};

  // Flatten the buffer onto the output bus
  always_comb begin
    seq_flat = '0;
    for (int unsigned k = 0; k < MAX_LEN; k++) begin
      seq_flat[k*IDX_W +: IDX_W] = entries[k];
    end
  end

endmodule
